// File: rtl/clk_div_pkg.sv
// Shared FSM state type and constants for the clk_div_sched divider/scheduler.
package clk_div_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    STOPPING = 2'd2
  } state_e;

  localparam int unsigned MIN_DIV = 2;

endpackage

// File: rtl/clk_div_core.sv
// Period counter and duty compare. With CLK_DIV_ODD50_EN defined, a falling-edge
// copy of the output stretches odd-ratio high phases by half a clk period.
module clk_div_core
  import clk_div_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic [CNT_W-1:0] div,
  input  logic             odd50,
  output logic             clkout,
  output logic             wrap
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             active_q;
  logic             clk_q, clk_d;
  logic             neg_q;
  logic [CNT_W:0]   high_len;
  logic             odd_div;

  // run describes the upcoming cycle; active_q says the current cycle is inside a period
  assign odd_div = div[0];
  assign wrap    = active_q && (cnt_q == (div - CNT_W'(1)));

  always_comb begin
    high_len = ({1'b0, div} + (CNT_W+1)'(1)) >> 1;
    if (odd50 && odd_div) begin
      high_len = {1'b0, div} >> 1;
    end
  end

  always_comb begin
    cnt_d = '0;
    if (run && active_q && !wrap) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    clk_d = run && ({1'b0, cnt_d} < high_len);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      active_q <= 1'b0;
      clk_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      active_q <= run;
      clk_q    <= clk_d;
    end
  end

`ifdef CLK_DIV_ODD50_EN
  always_ff @(negedge clk) begin
    if (!rst_n) begin
      neg_q <= 1'b0;
    end else begin
      neg_q <= clk_q;
    end
  end
`else
  assign neg_q = 1'b0;
`endif

  assign clkout = clk_q | (odd50 & odd_div & active_q & neg_q);

endmodule

// File: rtl/clk_div_sched.sv
// Run/stop FSM and ratio handshake around clk_div_core; new ratios switch only at
// period boundaries. CLK_DIV_ODD50_EN enables 50% duty for odd ratios.
module clk_div_sched
  import clk_div_pkg::*;
#(
  parameter int CNT_W       = 8,
  parameter int DEFAULT_DIV = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             clkout,
  output logic             period_start,
  output logic [CNT_W-1:0] cur_div,
  output logic             cfg_err,
  output logic             busy
);

  state_e           state_q, state_d;
  logic             pend_q, pend_d;
  logic [CNT_W-1:0] pend_div_q, pend_div_d;
  logic [CNT_W-1:0] cur_div_q, cur_div_d;
  logic             cfg_err_q, cfg_err_d;
  logic             ps_q, ps_d;
  logic             hs, cfg_legal, wrap, run_next, odd50;

`ifdef CLK_DIV_ODD50_EN
  assign odd50 = 1'b1;
`else
  assign odd50 = 1'b0;
`endif

  assign hs        = cfg_valid && !pend_q;
  assign cfg_legal = cfg_div >= CNT_W'(MIN_DIV);

  // A period whose last cycle coincides with en falling ends here, no STOPPING needed
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (en) state_d = RUN;
      RUN:      if (!en) state_d = wrap ? IDLE : STOPPING;
      STOPPING: begin
        if (en) begin
          state_d = RUN;
        end else if (wrap) begin
          state_d = IDLE;
        end
      end
      default:  state_d = IDLE;
    endcase
    run_next = (state_d != IDLE);
    ps_d     = run_next && ((state_q == IDLE) || wrap);
  end

  // Pending ratios land on a wrap or in IDLE; a fresh handshake never lands on the current wrap
  always_comb begin
    pend_d     = pend_q;
    pend_div_d = pend_div_q;
    cur_div_d  = cur_div_q;
    cfg_err_d  = 1'b0;
    if (pend_q && (wrap || (state_q == IDLE))) begin
      cur_div_d = pend_div_q;
      pend_d    = 1'b0;
    end
    if (hs) begin
      if (!cfg_legal) begin
        cfg_err_d = 1'b1;
      end else if (state_q == IDLE) begin
        cur_div_d = cfg_div;
      end else begin
        pend_d     = 1'b1;
        pend_div_d = cfg_div;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pend_q     <= 1'b0;
      pend_div_q <= '0;
      cur_div_q  <= CNT_W'(DEFAULT_DIV);
      cfg_err_q  <= 1'b0;
      ps_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      pend_div_q <= pend_div_d;
      cur_div_q  <= cur_div_d;
      cfg_err_q  <= cfg_err_d;
      ps_q       <= ps_d;
    end
  end

  clk_div_core #(
    .CNT_W(CNT_W)
  ) u_core (
    .clk   (clk),
    .rst_n (rst_n),
    .run   (run_next),
    .div   (cur_div_q),
    .odd50 (odd50),
    .clkout(clkout),
    .wrap  (wrap)
  );

  assign cfg_ready    = !pend_q;
  assign period_start = ps_q;
  assign cur_div      = cur_div_q;
  assign cfg_err      = cfg_err_q;
  assign busy         = (state_q != IDLE);

endmodule
